// File: rtl/fetch_pkg.sv
// Shared constants and the fetch buffer entry type for the instruction fetch stage.
package fetch_pkg;

  localparam int              PC_W      = 9;
  localparam logic [PC_W-1:0] RESET_PC  = 9'h000;
  localparam logic [31:0]     NOP_INSTR = 32'h00000013;
  localparam int              PC_STEP   = 4;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order FIFO holding fetched instruction/PC pairs ahead of the decoder.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       push_i,
  input  entry_t     push_data_i,
  input  logic       pop_i,
  output logic [1:0] count_o,
  output logic       head_valid_o,
  output entry_t     head_o
);

  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic [1:0] count_q, count_d;

  // Entry 0 is always the head, so outputs come straight from a register.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) head_d = push_data_i;
          else                 tail_d = push_data_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = push_data_i;
          end else begin
            head_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != 2'd0);
  assign head_o       = head_q;

  // Upstream credit accounting must never let a return land in a full buffer.
  push_into_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !flush_i && count_q == 2'd2));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, credit-based read issue to a synchronous imem, and the fetch buffer
// feeding the decoder over a valid/ready handshake.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter type             T        = logic [31:0],
  parameter int              PC_W     = fetch_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  T                imem_rdata,
  input  logic            i_redirect,
  input  logic [PC_W-1:0] i_redirect_pc,
  output logic            o_valid,
  output T                o_instruction,
  output logic [PC_W-1:0] o_pc,
  input  logic            i_ready
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    T                instr;
  } entry_t;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] redirect_target;
  logic [1:0]      count;
  logic [2:0]      used;
  logic            head_valid;
  logic            pop, push, issue;
  entry_t          head, push_data;

  assign pop  = head_valid & i_ready & ~i_redirect;
  assign push = inflight_q & ~i_redirect;

  // Buffered plus in-flight words after this cycle's pop must leave a free slot.
  assign used  = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = rst_n & ~i_redirect & (used < 3'd2);

  assign redirect_target = i_redirect_pc & ~PC_W'(3);

  always_comb begin
    push_data.pc    = inflight_pc_q;
    push_data.instr = imem_rdata;
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    if (i_redirect) begin
      pc_d       = redirect_target;
      inflight_d = 1'b0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = pc_q;
        pc_d          = pc_q + PC_W'(PC_STEP);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_buffer #(
    .entry_t(entry_t)
  ) u_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (i_redirect),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .count_o     (count),
    .head_valid_o(head_valid),
    .head_o      (head)
  );

  assign imem_en       = issue;
  assign imem_addr     = pc_q;
  assign o_valid       = head_valid;
  assign o_instruction = head_valid ? head.instr : T'(NOP_INSTR);
  assign o_pc          = head_valid ? head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random ready/redirect
// traffic, all compared against a stream-level model of the fetch stage.
module tb_fetch_unit;

  localparam int          PC_W     = 9;
  localparam logic [8:0]  RESET_PC = 9'h000;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk;
  logic        rst_n;
  logic        imem_en;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        i_redirect;
  logic [8:0]  i_redirect_pc;
  logic        o_valid;
  logic [31:0] o_instruction;
  logic [8:0]  o_pc;
  logic        i_ready;

  int checks = 0;
  int errors = 0;

  // Model: next PC the decoder must see, next PC memory must be asked for,
  // and cycles elapsed since the last restart (reset release or redirect).
  logic [8:0] expPc;
  logic [8:0] expIssue;
  int         sinceRestart;
  logic [8:0] wrapSeq [4];

  fetch_unit #(
    .T       (logic [31:0]),
    .PC_W    (PC_W),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .o_valid      (o_valid),
    .o_instruction(o_instruction),
    .o_pc         (o_pc),
    .i_ready      (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [8:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Synchronous instruction memory: data for an enabled address appears next cycle.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= memWord(imem_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic restartModel();
    expPc        = RESET_PC;
    expIssue     = RESET_PC;
    sinceRestart = 0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"}, 32'(o_valid), 32'd0);
    checkOutput({tag, "_instr"}, o_instruction, NOP);
    checkOutput({tag, "_pc"}, 32'(o_pc), 32'd0);
    checkOutput({tag, "_imem_en"}, 32'(imem_en), 32'd0);
    checkOutput({tag, "_imem_addr"}, 32'(imem_addr), 32'(RESET_PC));
  endtask

  // One clock cycle: drive at the falling edge, check the settled outputs, advance the model.
  task automatic applyStimulus(input logic ready, input logic redirect, input logic [8:0] rpc);
    @(negedge clk);
    i_ready       = ready;
    i_redirect    = redirect;
    i_redirect_pc = rpc;
    #2;
    checkOutput("o_valid", 32'(o_valid), 32'(sinceRestart >= 2));
    if (!o_valid) begin
      checkOutput("idle_instr", o_instruction, NOP);
      checkOutput("idle_pc", 32'(o_pc), 32'd0);
    end else if (ready && !redirect) begin
      checkOutput("o_pc", 32'(o_pc), 32'(expPc));
      checkOutput("o_instruction", o_instruction, memWord(expPc));
      expPc = expPc + 9'd4;
    end
    checkOutput("imem_addr", 32'(imem_addr), 32'(expIssue));
    if (redirect) begin
      checkOutput("redirect_no_issue", 32'(imem_en), 32'd0);
      expPc        = {rpc[8:2], 2'b00};
      expIssue     = expPc;
      sinceRestart = 0;
    end else begin
      if (imem_en) expIssue = expIssue + 9'd4;
      sinceRestart++;
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    i_ready       = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    imem_rdata    = '0;
    wrapSeq       = '{9'h1F8, 9'h1FC, 9'h000, 9'h004};
    restartModel();

    #3;
    checkResetState("reset");

    @(posedge clk);
    #1 rst_n = 1'b1;
    restartModel();

    $display("[TB] stream from reset, then decoder stall");
    repeat (5) applyStimulus(1'b1, 1'b0, 9'h000);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 9'h000);
      checkOutput("stall_no_issue", 32'(imem_en), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 9'h000);
    checkOutput("resume_issue", 32'(imem_en), 32'd1);
    checkOutput("resume_first_pc", 32'(o_pc), 32'h00C);
    repeat (3) applyStimulus(1'b1, 1'b0, 9'h000);

    $display("[TB] redirect with a word in flight");
    applyStimulus(1'b0, 1'b1, 9'h040);
    applyStimulus(1'b1, 1'b0, 9'h000);
    checkOutput("redirect_issue_en", 32'(imem_en), 32'd1);
    checkOutput("redirect_issue_addr", 32'(imem_addr), 32'h040);
    applyStimulus(1'b1, 1'b0, 9'h000);
    applyStimulus(1'b1, 1'b0, 9'h000);
    checkOutput("redirect_target_pc", 32'(o_pc), 32'h040);
    repeat (2) applyStimulus(1'b1, 1'b0, 9'h000);

    $display("[TB] redirect to an unaligned target with a full buffer");
    applyStimulus(1'b0, 1'b0, 9'h000);
    applyStimulus(1'b1, 1'b1, 9'h043);
    applyStimulus(1'b1, 1'b0, 9'h000);
    checkOutput("unaligned_issue_addr", 32'(imem_addr), 32'h040);
    repeat (4) applyStimulus(1'b1, 1'b0, 9'h000);

    $display("[TB] PC wrap-around");
    applyStimulus(1'b1, 1'b1, 9'h1F8);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 9'h000);
      if (k >= 2 && k < 6) checkOutput("wrap_pc", 32'(o_pc), 32'(wrapSeq[k-2]));
    end

    $display("[TB] asynchronous reset with a full buffer");
    repeat (3) applyStimulus(1'b0, 1'b0, 9'h000);
    #1 rst_n = 1'b0;
    #1 checkResetState("midreset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    restartModel();
    repeat (6) applyStimulus(1'b1, 1'b0, 9'h000);

    $display("[TB] random ready/redirect traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus(logic'($urandom_range(0, 3) != 0),
                    logic'($urandom_range(0, 15) == 0),
                    9'($urandom_range(0, 511)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
